// File: rtl/crc_pkg.sv
// crc_pkg: shared constants and FSM state type for the CRC-16/CCITT frame
// checker (crc16_chk) and its 4-bit next-state function (crc16_1021_step).
//   CRC16_POLY    - generator polynomial x^16+x^12+x^5+1 (0x1021)
//   CRC16_INIT    - default CRC register seed
//   CRC16_MIN_NIB - frames shorter than this many nibbles are "short"
//   state_t       - checker FSM states
package crc_pkg;

  localparam logic [15:0] CRC16_POLY    = 16'h1021;
  localparam logic [15:0] CRC16_INIT    = 16'hFFFF;
  localparam int unsigned CRC16_MIN_NIB = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/crc16_1021_step.sv
// crc16_1021_step: combinational CRC-16/CCITT next-state function for one
// 4-bit nibble, MSB (bit 3) first, no reflection, no xor-out.
// Ports:
//   crc_i  [15:0] - current CRC register
//   data_i [3:0]  - nibble; bit 3 is the first serial bit
//   crc_o  [15:0] - CRC register after shifting in the four bits
module crc16_1021_step
  import crc_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [3:0]  data_i,
  output logic [15:0] crc_o
);

  logic [15:0] c;
  logic [3:0]  d;
  logic        fb;

  // Unrolled bit-serial LFSR; the data nibble is shifted left so d[3] is
  // always the next serial bit.
  always_comb begin
    c  = crc_i;
    d  = data_i;
    fb = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      fb = c[15] ^ d[3];
      c  = {c[14:0], 1'b0} ^ (fb ? CRC16_POLY : '0);
      d  = {d[2:0], 1'b0};
    end
    crc_o = c;
  end

endmodule

// File: rtl/crc16_chk.sv
// crc16_chk: streaming CRC-16/CCITT (poly 0x1021) frame checker. Accepts a
// frame as 4-bit MSB-first nibbles (last four nibbles are the transmitted
// CRC) and reports pass/fail, nibble length and short-frame status on a held
// valid/ready result channel.
// Optional feature macro: CRC16_CHK_ERRCNT_EN enables the saturating
// failed-frame counter on err_cnt_o (tied to zero otherwise).
// Parameters:
//   INIT  - CRC seed loaded at frame start
//   LEN_W - width of the saturating nibble length counter
// Ports:
//   clk_i, rst_i (sync, active-high)
//   in_valid_i/in_ready_o/in_data_i/in_last_i - nibble input handshake
//   res_valid_o/res_ready_i                   - result handshake
//   res_ok_o, res_short_o, res_len_o          - registered result fields
//   err_cnt_o                                 - failed-frame count
module crc16_chk
  import crc_pkg::*;
#(
  parameter logic [15:0] INIT  = CRC16_INIT,
  parameter int unsigned LEN_W = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       in_data_i,
  input  logic             in_last_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic             res_ok_o,
  output logic             res_short_o,
  output logic [LEN_W-1:0] res_len_o,
  output logic [15:0]      err_cnt_o
);

  state_t             state_q;
  logic [15:0]        crc_q;
  logic [LEN_W-1:0]   len_q;
  logic               in_ready_q;
  logic               res_valid_q;
  logic               res_ok_q;
  logic               res_short_q;

  logic               beat;
  logic [15:0]        crc_src;
  logic [15:0]        crc_d;
  logic [LEN_W-1:0]   len_d;
  logic               short_d;
  logic               ok_d;

  assign beat    = in_valid_i & in_ready_q;
  // The seed is applied through the step function so the first nibble is
  // absorbed in the same cycle the frame starts.
  assign crc_src = (state_q == IDLE) ? INIT : crc_q;

  crc16_1021_step u_step (
    .crc_i  (crc_src),
    .data_i (in_data_i),
    .crc_o  (crc_d)
  );

  always_comb begin
    len_d = '0;
    if (state_q == IDLE) begin
      len_d = LEN_W'(1);
    end else if (len_q == '1) begin
      len_d = len_q;
    end else begin
      len_d = len_q + 1'b1;
    end
    short_d = (len_d < LEN_W'(CRC16_MIN_NIB));
    ok_d    = (crc_d == 16'h0000) & ~short_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      crc_q       <= INIT;
      len_q       <= '0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_ok_q    <= 1'b0;
      res_short_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, RUN: begin
          in_ready_q <= 1'b1;
          if (beat) begin
            crc_q <= crc_d;
            len_q <= len_d;
            if (in_last_i) begin
              state_q     <= RESP;
              in_ready_q  <= 1'b0;
              res_valid_q <= 1'b1;
              res_ok_q    <= ok_d;
              res_short_q <= short_d;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RESP: begin
          if (res_ready_i) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef CRC16_CHK_ERRCNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else if (res_valid_q && res_ready_i && !res_ok_q && err_cnt_q != '1) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = '0;
`endif

  assign in_ready_o  = in_ready_q;
  assign res_valid_o = res_valid_q;
  assign res_ok_o    = res_ok_q;
  assign res_short_o = res_short_q;
  assign res_len_o   = len_q;

endmodule
